// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries F-stage branch predictions to Execute, resolves them
// against the actual outcome and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 PCSrcPredF,
    input  logic [31:0]          PredPCTargetF,
    input  logic                 BranchOpEb0,
    input  logic                 PCSrcResE,
    input  logic [31:0]          PCTargetE,
    input  logic [31:0]          PCPlus4E,
    output logic                 PCSrcPredE,
    output logic                 TargetMatchE,
    output logic                 MispredictE,
    output logic [31:0]          RedirectPCE,
    output logic [CNT_WIDTH-1:0] BranchCount,
    output logic [CNT_WIDTH-1:0] MispredictCount
);
    logic        pcSrcPredD;
    logic [31:0] predPCTargetD;
    logic [31:0] predPCTargetE;
    logic        countEn;

    assign TargetMatchE = predPCTargetE == PCTargetE;
    // a taken prediction on a non-branch is an alias and must be undone
    assign MispredictE  = BranchOpEb0 ? (PCSrcPredE != PCSrcResE) | (PCSrcPredE & PCSrcResE & ~TargetMatchE)
                                      : PCSrcPredE;
    assign RedirectPCE  = (BranchOpEb0 & PCSrcResE) ? PCTargetE : PCPlus4E;
    assign countEn      = ~StallE & ~FlushE;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcSrcPredD      <= 1'b0;
            predPCTargetD   <= '0;
            PCSrcPredE      <= 1'b0;
            predPCTargetE   <= '0;
            BranchCount     <= '0;
            MispredictCount <= '0;
        end else begin
            if (FlushD) begin
                pcSrcPredD    <= 1'b0;
                predPCTargetD <= '0;
            end else if (!StallD) begin
                pcSrcPredD    <= PCSrcPredF;
                predPCTargetD <= PredPCTargetF;
            end
            if (FlushE) begin
                PCSrcPredE    <= 1'b0;
                predPCTargetE <= '0;
            end else if (!StallE) begin
                PCSrcPredE    <= pcSrcPredD;
                predPCTargetE <= predPCTargetD;
            end
            if (countEn && BranchOpEb0 && BranchCount != '1)
                BranchCount <= BranchCount + 1'b1;
            if (countEn && MispredictE && MispredictCount != '1)
                MispredictCount <= MispredictCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a stage-array reference model;
// a monitor pops expected outputs from a queue and compares. A 2-bit-counter instance covers saturation.
module tb_branch_resolve_unit;
    logic        clk = 0;
    logic        reset, StallD, FlushD, StallE, FlushE, PCSrcPredF, BranchOpEb0, PCSrcResE;
    logic [31:0] PredPCTargetF, PCTargetE, PCPlus4E;
    logic        PCSrcPredE, TargetMatchE, MispredictE;
    logic [31:0] RedirectPCE;
    logic [15:0] BranchCount, MispredictCount;
    logic        sPred, sMatch, sMis;
    logic [31:0] sRedir;
    logic [1:0]  sBranchCount, sMispredictCount;

    always #5 clk = ~clk;

    branch_resolve_unit #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
        .PCSrcPredF(PCSrcPredF), .PredPCTargetF(PredPCTargetF), .BranchOpEb0(BranchOpEb0),
        .PCSrcResE(PCSrcResE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .PCSrcPredE(PCSrcPredE), .TargetMatchE(TargetMatchE), .MispredictE(MispredictE),
        .RedirectPCE(RedirectPCE), .BranchCount(BranchCount), .MispredictCount(MispredictCount));

    branch_resolve_unit #(.CNT_WIDTH(2)) dutSat (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
        .PCSrcPredF(PCSrcPredF), .PredPCTargetF(PredPCTargetF), .BranchOpEb0(BranchOpEb0),
        .PCSrcResE(PCSrcResE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .PCSrcPredE(sPred), .TargetMatchE(sMatch), .MispredictE(sMis),
        .RedirectPCE(sRedir), .BranchCount(sBranchCount), .MispredictCount(sMispredictCount));

    typedef struct {
        logic        pred;
        logic        match;
        logic        mis;
        logic [31:0] redir;
        logic [15:0] bc;
        logic [15:0] mc;
        logic [1:0]  bcSat;
        logic [1:0]  mcSat;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    bit  live = 0;

    // stage[0] = D, stage[1] = E; each holds {taken, target}
    bit          stTaken[2];
    logic [31:0] stTarget[2];
    int          bcnt, mcnt, bcntSat, mcntSat;

    function automatic int satInc(int v, int maxv);
        return (v + 1 > maxv) ? maxv : v + 1;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic cycle(bit rst, bit sd, bit fd, bit se, bit fe, bit pf, logic [31:0] tf,
                         bit bop, bit res, logic [31:0] tgt, logic [31:0] p4);
        expT e;
        bit  mis;
        @(negedge clk);
        reset = rst; StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
        PCSrcPredF = pf; PredPCTargetF = tf; BranchOpEb0 = bop; PCSrcResE = res;
        PCTargetE = tgt; PCPlus4E = p4;
        if (!bop) mis = stTaken[1];
        else if (stTaken[1]) mis = !res || (stTarget[1] != tgt);
        else mis = res;
        if (live) begin
            e.pred  = stTaken[1];
            e.match = stTarget[1] == tgt;
            e.mis   = mis;
            e.redir = (bop && res) ? tgt : p4;
            e.bc    = 16'(bcnt);
            e.mc    = 16'(mcnt);
            e.bcSat = 2'(bcntSat);
            e.mcSat = 2'(mcntSat);
            expQ.push_back(e);
        end
        if (rst) begin
            stTaken = '{0, 0}; stTarget = '{0, 0};
            bcnt = 0; mcnt = 0; bcntSat = 0; mcntSat = 0;
            live = 1;
        end else begin
            if (!se && !fe) begin
                if (bop) begin bcnt = satInc(bcnt, 65535); bcntSat = satInc(bcntSat, 3); end
                if (mis) begin mcnt = satInc(mcnt, 65535); mcntSat = satInc(mcntSat, 3); end
            end
            if (fe) begin stTaken[1] = 0; stTarget[1] = 0; end
            else if (!se) begin stTaken[1] = stTaken[0]; stTarget[1] = stTarget[0]; end
            if (fd) begin stTaken[0] = 0; stTarget[0] = 0; end
            else if (!sd) begin stTaken[0] = pf; stTarget[0] = tf; end
        end
    endtask

    task automatic idle(bit bop = 0, bit res = 0, logic [31:0] tgt = 0, logic [31:0] p4 = 32'h4);
        cycle(0, 0, 0, 0, 0, 0, 0, bop, res, tgt, p4);
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk);
            #2;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("PCSrcPredE", 32'(PCSrcPredE), 32'(e.pred));
                check("TargetMatchE", 32'(TargetMatchE), 32'(e.match));
                check("MispredictE", 32'(MispredictE), 32'(e.mis));
                check("RedirectPCE", RedirectPCE, e.redir);
                check("BranchCount", 32'(BranchCount), 32'(e.bc));
                check("MispredictCount", 32'(MispredictCount), 32'(e.mc));
                check("BranchCountSat", 32'(sBranchCount), 32'(e.bcSat));
                check("MispredictCountSat", 32'(sMispredictCount), 32'(e.mcSat));
            end
        end
    end

    initial begin
        stTaken = '{0, 0}; stTarget = '{0, 0};
        bcnt = 0; mcnt = 0; bcntSat = 0; mcntSat = 0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // correct taken
        cycle(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 4);
        idle();
        idle(1, 1, 32'h100, 32'h44);
        // wrong target
        cycle(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 4);
        idle();
        idle(1, 1, 32'h200, 32'h44);
        // wrong direction
        cycle(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 4);
        idle();
        idle(1, 0, 32'h100, 32'h44);
        // aliased non-branch
        cycle(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 4);
        idle();
        idle(0, 0, 32'h100, 32'h80);
        // E stalled three cycles on a mispredicting branch, then released
        cycle(0, 0, 0, 0, 0, 1, 32'h300, 0, 0, 0, 4);
        idle();
        repeat (3) cycle(0, 1, 0, 1, 0, 0, 0, 1, 1, 32'h304, 32'h20);
        idle(1, 1, 32'h304, 32'h20);
        // flush D and E: bubbles must be silent
        cycle(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0, 4);
        cycle(0, 0, 0, 0, 0, 1, 32'h600, 0, 0, 0, 4);
        cycle(0, 0, 1, 0, 1, 0, 0, 1, 1, 32'h500, 32'h8);
        idle();
        idle();
        // saturation of the 2-bit counters, then reset mid-stall
        repeat (5) idle(1, 1, 32'h900, 32'h10);
        cycle(1, 1, 1, 1, 1, 1, 32'h700, 1, 1, 32'h700, 32'h10);
        idle(1, 0, 32'h0, 32'h10);
        idle();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 3) == 0) ? $urandom : 32'(($urandom_range(1, 2)) << 8);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, 1'($urandom), tg,
                  1'($urandom), 1'($urandom), 32'(($urandom_range(1, 2)) << 8), $urandom);
        end
        @(negedge clk);
        #5;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
